// File: rtl/hc194_rx.sv
// rtl/hc194_rx.sv - serial nibble receiver for hc194-style shifter output (start, 4 data, stop)
module hc194_rx (
    input  logic       CP,
    input  logic       MRN,
    input  logic       SIN,
    input  logic       SEN,
    input  logic       DIR,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       QV,
    output logic       FERR,
    output logic       BUSY,
    output logic [3:0] ERRCNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] bit_cnt;
    logic [3:0] shadow;
    logic [3:0] q;
    logic       frame_dir;
    logic       start_bit;
    logic       shift_bit;
    logic       stop_ok;
    logic       stop_bad;

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_bit = 1'b0;
        shift_bit = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        if (SEN) begin
            case (state)
                IDLE: begin
                    if (!SIN) begin
                        start_bit = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    shift_bit = 1'b1;
                    if (bit_cnt == 2'd3) begin
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    stop_ok   = SIN;
                    stop_bad  = !SIN;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Direction is frozen at the start bit so mid-frame DIR changes cannot scramble placement.
    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            bit_cnt   <= 2'd0;
            shadow    <= 4'd0;
            frame_dir <= 1'b0;
            q         <= 4'd0;
            QV        <= 1'b0;
            FERR      <= 1'b0;
            BUSY      <= 1'b0;
            ERRCNT    <= 4'd0;
        end else begin
            QV   <= stop_ok;
            FERR <= stop_bad;
            BUSY <= (state_nxt != IDLE);
            if (start_bit) begin
                bit_cnt   <= 2'd0;
                frame_dir <= DIR;
            end
            if (shift_bit) begin
                bit_cnt <= bit_cnt + 2'd1;
                if (frame_dir) begin
                    shadow <= {SIN, shadow[3:1]};
                end else begin
                    shadow <= {shadow[2:0], SIN};
                end
            end
            if (stop_ok) begin
                q <= shadow;
            end
            if (stop_bad && (ERRCNT != 4'hF)) begin
                ERRCNT <= ERRCNT + 4'd1;
            end
        end
    end

    assign Q0 = q[0];
    assign Q1 = q[1];
    assign Q2 = q[2];
    assign Q3 = q[3];

endmodule

// File: tb/tb_hc194_rx.sv
// tb/tb_hc194_rx.sv - directed self-checking bench for hc194_rx
module tb_hc194_rx;

    logic       CP;
    logic       MRN;
    logic       SIN;
    logic       SEN;
    logic       DIR;
    logic       Q0;
    logic       Q1;
    logic       Q2;
    logic       Q3;
    logic       QV;
    logic       FERR;
    logic       BUSY;
    logic [3:0] ERRCNT;

    int errors;
    int checks;
    int qv_cnt;
    int ferr_cnt;
    int sen_edges;
    int qv_edge_a;
    int qv_edge_b;

    hc194_rx dut (
        .CP     (CP),
        .MRN    (MRN),
        .SIN    (SIN),
        .SEN    (SEN),
        .DIR    (DIR),
        .Q0     (Q0),
        .Q1     (Q1),
        .Q2     (Q2),
        .Q3     (Q3),
        .QV     (QV),
        .FERR   (FERR),
        .BUSY   (BUSY),
        .ERRCNT (ERRCNT)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge CP);
            SEN = 1'b0;
            @(posedge CP);
            #1;
            if (QV) qv_cnt++;
            if (FERR) ferr_cnt++;
        end
        @(negedge CP);
        SIN = b;
        SEN = 1'b1;
        @(posedge CP);
        #1;
        sen_edges++;
        if (QV) begin
            qv_cnt++;
            qv_edge_b = qv_edge_a;
            qv_edge_a = sen_edges;
        end
        if (FERR) ferr_cnt++;
    endtask

    task automatic idle_cycle();
        @(negedge CP);
        SEN = 1'b0;
        SIN = 1'b1;
        @(posedge CP);
        #1;
    endtask

    // data is sent msb first; toggle flips DIR before every data bit
    task automatic send_frame(input logic [3:0] data, input logic dir, input logic stop,
                              input int gap, input logic toggle);
        qv_cnt   = 0;
        ferr_cnt = 0;
        DIR = dir;
        send_bit(1'b0, gap);
        for (int i = 3; i >= 0; i--) begin
            if (toggle) DIR = ~DIR;
            send_bit(data[i], gap);
        end
        send_bit(stop, gap);
    endtask

    task automatic check_good(input string name, input logic [3:0] exp_q);
        checks++;
        if ({Q3, Q2, Q1, Q0} !== exp_q || QV !== 1'b1 || qv_cnt != 1 || FERR !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s: q=%b qv=%b qv_cnt=%0d ferr=%b busy=%b, required q=%b qv=1 qv_cnt=1 ferr=0 busy=0",
                     name, {Q3, Q2, Q1, Q0}, QV, qv_cnt, FERR, BUSY, exp_q);
        end
    endtask

    task automatic test_reset();
        MRN = 1'b0; SIN = 1'b1; SEN = 1'b0; DIR = 1'b0;
        repeat (2) @(posedge CP);
        #1;
        checks++;
        if ({Q3, Q2, Q1, Q0, QV, FERR, BUSY, ERRCNT} !== 11'd0) begin
            errors++;
            $display("FAIL reset: q=%b qv=%b ferr=%b busy=%b errcnt=%0d, required all 0",
                     {Q3, Q2, Q1, Q0}, QV, FERR, BUSY, ERRCNT);
        end
        @(negedge CP);
        MRN = 1'b1;
    endtask

    task automatic test_right();
        qv_cnt = 0;
        DIR = 1'b0;
        send_bit(1'b0, 0);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1", BUSY);
        end
        for (int i = 0; i < 4; i++) begin
            send_bit((i == 1) ? 1'b0 : 1'b1, 0);
            checks++;
            if (QV !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL right_mid bit%0d: qv=%b busy=%b, required qv=0 busy=1", i, QV, BUSY);
            end
        end
        send_bit(1'b1, 0);
        check_good("right_frame", 4'b1011);
        idle_cycle();
        checks++;
        if (QV !== 1'b0 || {Q3, Q2, Q1, Q0} !== 4'b1011) begin
            errors++;
            $display("FAIL qv_one_cycle: qv=%b q=%b, required qv=0 q=1011", QV, {Q3, Q2, Q1, Q0});
        end
    endtask

    task automatic test_left();
        send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
        check_good("left_frame", 4'b1101);
        idle_cycle();
    endtask

    task automatic test_dir_toggle();
        send_frame(4'b0111, 1'b0, 1'b1, 0, 1'b1);
        check_good("dir_toggle_right", 4'b0111);
        idle_cycle();
        send_frame(4'b0111, 1'b1, 1'b1, 0, 1'b1);
        check_good("dir_toggle_left", 4'b1110);
        idle_cycle();
    endtask

    task automatic test_framing_error();
        send_frame(4'b1111, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (FERR !== 1'b1 || QV !== 1'b0 || qv_cnt != 0 || {Q3, Q2, Q1, Q0} !== 4'b1110 || ERRCNT !== 4'd1) begin
            errors++;
            $display("FAIL ferr_frame: ferr=%b qv=%b q=%b errcnt=%0d, required ferr=1 qv=0 q=1110 errcnt=1",
                     FERR, QV, {Q3, Q2, Q1, Q0}, ERRCNT);
        end
        idle_cycle();
        checks++;
        if (FERR !== 1'b0) begin
            errors++;
            $display("FAIL ferr_one_cycle: got %b, required 0", FERR);
        end
        for (int n = 2; n <= 16; n++) begin
            send_frame(4'b1111, 1'b0, 1'b0, 0, 1'b0);
        end
        checks++;
        if (ERRCNT !== 4'd15 || FERR !== 1'b1) begin
            errors++;
            $display("FAIL errcnt_16: errcnt=%0d ferr=%b, required errcnt=15 ferr=1", ERRCNT, FERR);
        end
        send_frame(4'b1111, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (ERRCNT !== 4'd15) begin
            errors++;
            $display("FAIL errcnt_sat: got %0d, required 15", ERRCNT);
        end
        idle_cycle();
    endtask

    task automatic test_gapped();
        send_frame(4'b1011, 1'b0, 1'b1, 3, 1'b0);
        check_good("gapped_frame", 4'b1011);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        qv_edge_a = 0;
        qv_edge_b = 0;
        send_frame(4'b1001, 1'b0, 1'b1, 0, 1'b0);
        check_good("b2b_first", 4'b1001);
        send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
        check_good("b2b_second", 4'b0110);
        checks++;
        if (qv_edge_a - qv_edge_b != 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d edges, required 6", qv_edge_a - qv_edge_b);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_frame();
        qv_cnt   = 0;
        ferr_cnt = 0;
        DIR = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #1;
        MRN = 1'b0;
        #1;
        checks++;
        if ({Q3, Q2, Q1, Q0, QV, FERR, BUSY, ERRCNT} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_async: q=%b qv=%b ferr=%b busy=%b errcnt=%0d, required all 0",
                     {Q3, Q2, Q1, Q0}, QV, FERR, BUSY, ERRCNT);
        end
        @(negedge CP);
        SEN = 1'b0;
        MRN = 1'b1;
        // these would finish the discarded frame; the block must treat them as idle line
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        checks++;
        if (qv_cnt != 0 || ferr_cnt != 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: qv_cnt=%0d ferr_cnt=%0d busy=%b, required 0 0 0", qv_cnt, ferr_cnt, BUSY);
        end
        send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);
        check_good("after_reset_frame", 4'b1011);
        idle_cycle();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        qv_cnt    = 0;
        ferr_cnt  = 0;
        sen_edges = 0;
        qv_edge_a = 0;
        qv_edge_b = 0;
        test_reset();
        test_right();
        test_left();
        test_dir_toggle();
        test_framing_error();
        test_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
